// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: aluop codes,
// bus types, FSM state encoding and the divide-by-zero result constant.
package ex_muldiv_pkg;

  localparam int REG_W = 32;

  typedef logic [7:0]         aluop_t;
  typedef logic [REG_W-1:0]   reg_bus_t;
  typedef logic [2*REG_W-1:0] double_reg_bus_t;

  localparam aluop_t EXE_NOP_OP   = 8'b0000_0000;
  localparam aluop_t EXE_MULT_OP  = 8'b0001_1000;
  localparam aluop_t EXE_MULTU_OP = 8'b0001_1001;
  localparam aluop_t EXE_DIV_OP   = 8'b0001_1010;
  localparam aluop_t EXE_DIVU_OP  = 8'b0001_1011;
  localparam aluop_t EXE_MADD_OP  = 8'b1010_0110;
  localparam aluop_t EXE_MADDU_OP = 8'b1010_1000;
  localparam aluop_t EXE_MSUB_OP  = 8'b1010_1010;
  localparam aluop_t EXE_MSUBU_OP = 8'b1010_1011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DIV_ON,
    ST_DIV_END
  } state_t;

  localparam reg_bus_t DIV_ZERO = '0;

endpackage

// File: rtl/ex_muldiv_if.sv
// Operand/result bundle between the id_ex register and the mul/div unit.
// master = pipeline side, slave = ex_muldiv.
interface ex_muldiv_if
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_W = 32
);
  aluop_t              aluop_i;
  logic [DATA_W-1:0]   reg1_i;
  logic [DATA_W-1:0]   reg2_i;
  logic [DATA_W-1:0]   hi_i;
  logic [DATA_W-1:0]   lo_i;
  logic                annul_i;
  logic                stallreq_o;
  logic                whilo_o;
  logic [DATA_W-1:0]   hi_o;
  logic [DATA_W-1:0]   lo_o;

  modport master (
    output aluop_i, reg1_i, reg2_i, hi_i, lo_i, annul_i,
    input  stallreq_o, whilo_o, hi_o, lo_o
  );

  modport slave (
    input  aluop_i, reg1_i, reg2_i, hi_i, lo_i, annul_i,
    output stallreq_o, whilo_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_muldiv_div_core.sv
// Iterative radix-2 restoring divider on unsigned magnitudes, one quotient
// bit per step; sign handling lives in the parent.
module ex_muldiv_div_core #(
  parameter int DATA_W   = 32,
  parameter int DIV_ITER = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic              annul,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              ready,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CNT_W = $clog2(DIV_ITER);

  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] dsr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W:0]   partial;
  logic              fits;
  logic [DATA_W-1:0] rem_sub;

  // Shift the next dividend bit into the 33-bit partial remainder and trial-subtract.
  assign partial = {rem_q, quo_q[DATA_W-1]};
  assign fits    = (partial >= {1'b0, dsr_q});
  assign rem_sub = DATA_W'(partial - {1'b0, dsr_q});

  // High while the current step produces the final quotient bit.
  assign ready     = (cnt_q == CNT_W'(DIV_ITER - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
      cnt_q <= '0;
    end else if (annul) begin
      cnt_q <= '0;
    end else if (step) begin
      rem_q <= fits ? rem_sub : partial[DATA_W-1:0];
      quo_q <= {quo_q[DATA_W-2:0], fits};
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: single-cycle MULT/MULTU, two-cycle
// MADD/MSUB accumulate and a multi-cycle DIV/DIVU, writing HI/LO.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);

  localparam int DW2 = 2 * DATA_W;

  state_t            state, state_nxt;
  logic [DW2-1:0]    prod_q;
  logic              sub_q, sign1_q, sign2_q;
  logic              is_mul, is_acc, is_div, op_signed, op_sub;
  logic [DW2-1:0]    mul_s, mul_u, product, acc_sum;
  logic              neg1, neg2, div_zero, div_start, div_step, div_ready;
  logic [DATA_W-1:0] mag1, mag2, div_quo, div_rem, quo_fix, rem_fix;
  logic              stall, whilo;
  logic [DATA_W-1:0] hi_d, lo_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    is_mul    = 1'b0;
    is_acc    = 1'b0;
    is_div    = 1'b0;
    op_signed = 1'b0;
    op_sub    = 1'b0;
    case (bus.aluop_i)
      EXE_MULT_OP:  begin is_mul = 1'b1; op_signed = 1'b1; end
      EXE_MULTU_OP: is_mul = 1'b1;
      EXE_MADD_OP:  begin is_acc = 1'b1; op_signed = 1'b1; end
      EXE_MADDU_OP: is_acc = 1'b1;
      EXE_MSUB_OP:  begin is_acc = 1'b1; op_signed = 1'b1; op_sub = 1'b1; end
      EXE_MSUBU_OP: begin is_acc = 1'b1; op_sub = 1'b1; end
      EXE_DIV_OP:   begin is_div = 1'b1; op_signed = 1'b1; end
      EXE_DIVU_OP:  is_div = 1'b1;
      default:      ;
    endcase
  end

  assign mul_s   = DW2'($signed(bus.reg1_i)) * DW2'($signed(bus.reg2_i));
  assign mul_u   = DW2'(bus.reg1_i) * DW2'(bus.reg2_i);
  assign product = op_signed ? mul_s : mul_u;
  assign acc_sum = sub_q ? {bus.hi_i, bus.lo_i} - prod_q
                         : {bus.hi_i, bus.lo_i} + prod_q;

  // The divider works on magnitudes; the most negative value maps onto itself.
  assign neg1     = op_signed & bus.reg1_i[DATA_W-1];
  assign neg2     = op_signed & bus.reg2_i[DATA_W-1];
  assign mag1     = neg1 ? -bus.reg1_i : bus.reg1_i;
  assign mag2     = neg2 ? -bus.reg2_i : bus.reg2_i;
  assign div_zero = (bus.reg2_i == '0);

  assign div_start = (state == ST_IDLE) && is_div && !div_zero && !bus.annul_i;
  assign div_step  = (state == ST_DIV_ON) && !bus.annul_i;
  assign quo_fix   = (sign1_q ^ sign2_q) ? -div_quo : div_quo;
  assign rem_fix   = sign1_q ? -div_rem : div_rem;

  ex_muldiv_div_core #(
    .DATA_W   (DATA_W),
    .DIV_ITER (DIV_ITER)
  ) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .step      (div_step),
    .annul     (bus.annul_i),
    .dividend  (mag1),
    .divisor   (mag2),
    .ready     (div_ready),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    whilo     = 1'b0;
    hi_d      = '0;
    lo_d      = '0;
    case (state)
      ST_IDLE: begin
        if (is_mul) begin
          whilo        = 1'b1;
          {hi_d, lo_d} = product;
        end else if (is_acc) begin
          stall     = 1'b1;
          state_nxt = ST_ACC;
        end else if (is_div && div_zero) begin
          whilo = 1'b1;
          hi_d  = DATA_W'(DIV_ZERO);
          lo_d  = DATA_W'(DIV_ZERO);
        end else if (is_div) begin
          stall     = 1'b1;
          state_nxt = ST_DIV_ON;
        end
      end
      ST_ACC: begin
        whilo        = 1'b1;
        {hi_d, lo_d} = acc_sum;
        state_nxt    = ST_IDLE;
      end
      ST_DIV_ON: begin
        stall = 1'b1;
        if (div_ready) state_nxt = ST_DIV_END;
      end
      ST_DIV_END: begin
        whilo     = 1'b1;
        hi_d      = rem_fix;
        lo_d      = quo_fix;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A flush beats completion: nothing is written and the pipeline is released.
    if (bus.annul_i) begin
      state_nxt = ST_IDLE;
      stall     = 1'b0;
      whilo     = 1'b0;
      hi_d      = '0;
      lo_d      = '0;
    end
  end

  // Outputs are forced quiet while reset is held, independent of the inputs.
  assign bus.stallreq_o = rst & stall;
  assign bus.whilo_o    = rst & whilo;
  assign bus.hi_o       = rst ? hi_d : '0;
  assign bus.lo_o       = rst ? lo_d : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      prod_q  <= '0;
      sub_q   <= 1'b0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && is_acc && !bus.annul_i) begin
        prod_q <= product;
        sub_q  <= op_sub;
      end
      if (div_start) begin
        sign1_q <= neg1;
        sign2_q <= neg2;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: expected HI/LO writes are queued at issue
// and compared whenever the unit pulses whilo_o.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [63:0] sb[$];

  ex_muldiv_if #(.DATA_W(32)) bus ();

  ex_muldiv #(
    .DATA_W   (32),
    .DIV_ITER (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every write pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.whilo_o === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got hi=%h lo=%h, expected no write", bus.hi_o, bus.lo_o);
      end else begin
        logic [63:0] exp_v;
        exp_v = sb.pop_front();
        if ({bus.hi_o, bus.lo_o} !== exp_v)
          begin
            failures++;
            $display("FAIL hilo_write got hi=%h lo=%h, expected hi=%h lo=%h",
                     bus.hi_o, bus.lo_o, exp_v[63:32], exp_v[31:0]);
          end
      end
    end
  end

  task automatic drive(input aluop_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] h, input logic [31:0] l);
    bus.aluop_i = op;
    bus.reg1_i  = a;
    bus.reg2_i  = b;
    bus.hi_i    = h;
    bus.lo_i    = l;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issues a divide and checks write latency and stall length; the caller idles the bus.
  task automatic run_div(input string name, input aluop_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
    int n_stall;
    int wr_at;
    n_stall = 0;
    wr_at   = -1;
    sb.push_back({exp_hi, exp_lo});
    drive(op, a, b, 32'h0, 32'h0);
    for (int i = 0; i < 40 && wr_at < 0; i++) begin
      @(negedge clk);
      if (bus.stallreq_o === 1'b1) n_stall++;
      if (bus.whilo_o === 1'b1) wr_at = i;
      next_cycle();
    end
    checks++;
    if (wr_at != 33) begin
      failures++;
      $display("FAIL %s_latency got %0d, expected 33", name, wr_at);
    end
    checks++;
    if (n_stall != 33) begin
      failures++;
      $display("FAIL %s_stall_cycles got %0d, expected 33", name, n_stall);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.annul_i = 1'b0;
    drive(EXE_MULT_OP, 32'd3, 32'd3, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if ({bus.stallreq_o, bus.whilo_o, bus.hi_o, bus.lo_o} !== 66'h0) begin
      failures++;
      $display("FAIL reset_outputs got stall=%b whilo=%b hi=%h lo=%h, expected all 0",
               bus.stallreq_o, bus.whilo_o, bus.hi_o, bus.lo_o);
    end
    drive(EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 32'h0);
    #2 rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_mult();
    sb.push_back(64'hFFFF_FFFF_FFFF_FFFA);
    drive(EXE_MULT_OP, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if ({bus.stallreq_o, bus.whilo_o} !== 2'b01) begin
      failures++;
      $display("FAIL mult_ctrl got stall=%b whilo=%b, expected stall=0 whilo=1",
               bus.stallreq_o, bus.whilo_o);
    end
    next_cycle();
    sb.push_back(64'h0000_0002_FFFF_FFFA);
    drive(EXE_MULTU_OP, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if ({bus.stallreq_o, bus.whilo_o} !== 2'b01) begin
      failures++;
      $display("FAIL multu_ctrl got stall=%b whilo=%b, expected stall=0 whilo=1",
               bus.stallreq_o, bus.whilo_o);
    end
    next_cycle();
    drive(EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 32'h0);
    next_cycle();
  endtask

  // Issue cycle uses (h0,l0); the accumulate cycle presents (h1,l1) as forwarded HI/LO.
  task automatic acc_op(input string name, input aluop_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] h0, input logic [31:0] l0,
                        input logic [31:0] h1, input logic [31:0] l1,
                        input logic [63:0] exp_v);
    sb.push_back(exp_v);
    drive(op, a, b, h0, l0);
    @(negedge clk);
    checks++;
    if ({bus.stallreq_o, bus.whilo_o} !== 2'b10) begin
      failures++;
      $display("FAIL %s_issue got stall=%b whilo=%b, expected stall=1 whilo=0",
               name, bus.stallreq_o, bus.whilo_o);
    end
    next_cycle();
    drive(op, a, b, h1, l1);
    @(negedge clk);
    checks++;
    if ({bus.stallreq_o, bus.whilo_o} !== 2'b01) begin
      failures++;
      $display("FAIL %s_acc got stall=%b whilo=%b, expected stall=0 whilo=1",
               name, bus.stallreq_o, bus.whilo_o);
    end
    next_cycle();
    drive(EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_madd_msub();
    acc_op("madd", EXE_MADD_OP, 32'd5, 32'hFFFF_FFFE, 32'd0, 32'd20, 32'd0, 32'd20,
           64'd10);
    acc_op("msubu", EXE_MSUBU_OP, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0,
           64'hFFFF_FFFF_FFFF_FFFF);
    acc_op("madd_wrap", EXE_MADD_OP, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0);
    acc_op("maddu_fwd", EXE_MADDU_OP, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0, 32'd100,
           64'd106);
    acc_op("msub", EXE_MSUB_OP, 32'hFFFF_FFFD, 32'd4, 32'd0, 32'd5, 32'd0, 32'd5,
           64'd17);
    next_cycle();
  endtask

  task automatic test_div();
    run_div("div_neg", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    drive(EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 32'h0);
    next_cycle();
    run_div("div_ovf", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
    drive(EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 32'h0);
    next_cycle();
    run_div("div_mixed", EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    drive(EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 32'h0);
    next_cycle();
  endtask

  task automatic test_div_zero();
    sb.push_back(64'h0);
    drive(EXE_DIV_OP, 32'd12345, 32'd0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if ({bus.stallreq_o, bus.whilo_o} !== 2'b01) begin
      failures++;
      $display("FAIL div_zero_ctrl got stall=%b whilo=%b, expected stall=0 whilo=1",
               bus.stallreq_o, bus.whilo_o);
    end
    next_cycle();
    drive(EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.stallreq_o !== 1'b0) begin
      failures++;
      $display("FAIL div_zero_idle got stall=%b, expected 0", bus.stallreq_o);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    run_div("b2b_first", EXE_DIVU_OP, 32'd100, 32'd7, 32'd14, 32'd2);
    run_div("b2b_second", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15);
    drive(EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 32'h0);
    next_cycle();
  endtask

  task automatic test_annul();
    int n_stall;
    n_stall = 0;
    drive(EXE_DIV_OP, 32'd1000, 32'd3, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.stallreq_o === 1'b1) n_stall++;
      next_cycle();
    end
    checks++;
    if (n_stall != 10) begin
      failures++;
      $display("FAIL annul_pre_stall got %0d, expected 10", n_stall);
    end
    bus.annul_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.stallreq_o, bus.whilo_o} !== 2'b00) begin
      failures++;
      $display("FAIL annul_cycle got stall=%b whilo=%b, expected 0 0",
               bus.stallreq_o, bus.whilo_o);
    end
    next_cycle();
    bus.annul_i = 1'b0;
    drive(EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 32'h0);
    n_stall = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.stallreq_o === 1'b1) n_stall++;
      next_cycle();
    end
    checks++;
    if (n_stall != 0) begin
      failures++;
      $display("FAIL annul_idle_stall got %0d, expected 0", n_stall);
    end
    run_div("after_annul", EXE_DIVU_OP, 32'd9, 32'd3, 32'd3, 32'd0);
    drive(EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 32'h0);
    next_cycle();
  endtask

  task automatic test_reset_mid_div();
    drive(EXE_DIVU_OP, 32'd50, 32'd5, 32'h0, 32'h0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({bus.stallreq_o, bus.whilo_o, bus.hi_o, bus.lo_o} !== 66'h0) begin
      failures++;
      $display("FAIL reset_mid_div got stall=%b whilo=%b hi=%h lo=%h, expected all 0",
               bus.stallreq_o, bus.whilo_o, bus.hi_o, bus.lo_o);
    end
    drive(EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #3 rst = 1'b1;
    next_cycle();
    run_div("after_reset", EXE_DIVU_OP, 32'd8, 32'd2, 32'd4, 32'd0);
    drive(EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 32'h0);
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_mult();
    test_madd_msub();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_annul();
    test_reset_mid_div();
    repeat (3) next_cycle();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL pending_writes got %0d, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Multi-cycle multiply/divide unit inside the EX stage, directly downstream of the decode stage through the id_ex pipeline register.
- Consumes the decoded aluop and forwarded source operands for MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV and DIVU.
- Produces the HI/LO write-back and a stall request to the pipeline control.
- Single-cycle ops complete in the issue cycle; accumulate and divide ops hold the pipeline until they finish.

Parameters:
DATA_W, 32, operand width; HI and LO are each DATA_W.
DIV_ITER, 32, divide iterations, one quotient bit per cycle; must equal DATA_W.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
aluop_i  input  8  decoded operation; EXE_*_OP codes
reg1_i  input  32  source operand 1 (rs), already forwarded
reg2_i  input  32  source operand 2 (rt), already forwarded
hi_i  input  32  current HI value, forwarded from MEM/WB
lo_i  input  32  current LO value, forwarded from MEM/WB
annul_i  input  1  abort any in-flight operation (flush)
stallreq_o  output  1  hold IF/ID/EX until the operation completes
whilo_o  output  1  write enable for HI/LO this cycle
hi_o  output  32  HI result
lo_o  output  32  LO result

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; all internal registers 0; stallreq_o=0, whilo_o=0, hi_o=0, lo_o=0.
- While the unit stalls, aluop_i and the operands are held stable by the upstream stall. The unit samples operands only on the issue cycle.
- States: IDLE, ACC, DIV_ON, DIV_END.

IDLE:
- MULT/MULTU: 64-bit product, signed or unsigned. Combinational result; whilo_o=1 in the same cycle; no stall.
- MADD/MADDU/MSUB/MSUBU:
  - Register the 64-bit product (signed for MADD/MSUB, unsigned for *U).
  - stallreq_o=1; go to ACC.
- DIV/DIVU with reg2_i=0: hi_o=lo_o=0, whilo_o=1 in the same cycle; no stall; stay in IDLE.
- DIV/DIVU with reg2_i≠0:
  - Latch the magnitudes (absolute values for DIV) and the two sign bits.
  - Clear the iteration counter; stallreq_o=1; go to DIV_ON.
- Any other aluop: whilo_o=0, stallreq_o=0.

ACC (one cycle):
- {hi_o,lo_o} = {hi_i,lo_i} + product (MADD*) or − product (MSUB*), taken mod 2^64.
- hi_i/lo_i are sampled in this cycle, so HI/LO writes from the preceding instruction are seen.
- whilo_o=1, stallreq_o=0; go to IDLE.

DIV_ON:
- Radix-2 restoring division, one quotient bit per cycle, for DIV_ITER cycles.
- stallreq_o=1 throughout.
- On the cycle with counter = DIV_ITER−1, go to DIV_END.

DIV_END (one cycle):
- Fix up signs for DIV: quotient negated if sign1^sign2; remainder takes the sign of reg1.
- lo_o=quotient, hi_o=remainder; whilo_o=1, stallreq_o=0; go to IDLE.

Latency and boundaries:
- Divide latency: issue cycle + 32 DIV_ON cycles + DIV_END. Result is written 33 cycles after issue; stallreq_o is high for cycles 0..32.
- annul_i=1 in any state: next state IDLE; whilo_o forced 0 in that cycle; stallreq_o=0. Annul has priority over completion.
- Overflow is never trapped:
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - MADD wraps mod 2^64.
- whilo_o is a one-cycle pulse per completed instruction. Back-to-back divides re-enter DIV_ON from IDLE on the cycle after DIV_END.

Decomposition:
- defines.v (shared):
  - aluop codes EXE_MULT_OP, EXE_MULTU_OP, EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP, EXE_DIV_OP, EXE_DIVU_OP
  - RegBus, DoubleRegBus, AluOpBus
  - state encodings and the DivZero constant
- One sub-module, div_core:
  - Iterative restoring divider with start, annul and ready handshake, 33-bit partial remainder.
  - ex_muldiv keeps the FSM, sign handling and MADD/MSUB accumulation.

Test Plan:
- MULT 0xFFFFFFFE × 3: in the issue cycle whilo_o=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU of the same operands: hi=0x00000002, lo=0xFFFFFFFA. stallreq_o stays 0.
- MADD 5×(−2) with hi_i=0, lo_i=20: issue cycle stallreq=1, whilo=0. Next cycle hi=0, lo=10, whilo=1. MSUBU 1×1 with HI/LO=0: hi=lo=0xFFFFFFFF.
- DIV −7/2: stallreq high for exactly 33 cycles; cycle 33 lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7: lo=14, hi=2.
- DIV x/0: same-cycle whilo=1, hi=lo=0, no stall. DIV 0x80000000/−1: lo=0x80000000, hi=0.
- annul_i pulsed at DIV_ON cycle 10: FSM returns to IDLE, stallreq drops, no whilo pulse. A following DIVU 9/3 completes normally (lo=3, hi=0).
- rst asserted mid-divide: outputs go to 0 asynchronously. After release, a new DIVU 8/2 yields lo=4, hi=0 after 33 cycles.
